// File: rtl/cp0_regfile_if.sv
// Pipeline-to-CP0 connection: WB-stage writes/exception entry and the ID-stage mfc0 read port.
// Strobe semantics: no valid/ready handshake; wr_cp0op and exc_req are single-cycle commands sampled on every rising edge.
interface cp0_regfile_if;
  logic [2:0]  wr_cp0op;
  logic [4:0]  wr_cs;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [4:0]  id_cs;
  logic [2:0]  id_sel;
  logic [31:0] id_rdata;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic [4:0]  exc_code;
  logic [31:0] epc_out;
  logic        irq_pending;
  logic        status_exl;

  modport master (
    output wr_cp0op, wr_cs, wr_sel, wr_data, id_cs, id_sel, exc_req, exc_pc, exc_code,
    input  id_rdata, epc_out, irq_pending, status_exl
  );

  modport slave (
    input  wr_cp0op, wr_cs, wr_sel, wr_data, id_cs, id_sel, exc_req, exc_pc, exc_code,
    output id_rdata, epc_out, irq_pending, status_exl
  );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file: Count/Compare timer, Status, Cause and EPC with exception entry and eret.
// Same-cycle priority is exception > eret > mtc0; the Count tick and timer match always happen.
module cp0_regfile (
  input  logic            clk,
  input  logic            rst,
  cp0_regfile_if.slave    bus
);
  localparam logic [4:0]  CS_COUNT   = 5'd9;
  localparam logic [4:0]  CS_COMPARE = 5'd11;
  localparam logic [4:0]  CS_STATUS  = 5'd12;
  localparam logic [4:0]  CS_CAUSE   = 5'd13;
  localparam logic [4:0]  CS_EPC     = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] count_q, compare_q, status_q, cause_q, epc_q;
  logic [31:0] cause_d;
  logic        do_exc, do_eret, do_mtc0, timer_hit;

  assign do_exc    = bus.exc_req;
  assign do_eret   = !bus.exc_req && (bus.wr_cp0op == 3'b100);
  assign do_mtc0   = !bus.exc_req && (bus.wr_cp0op == 3'b010) && (bus.wr_sel == 3'd0);
  assign timer_hit = (count_q == compare_q);

  // A timer match in the same cycle as an mtc0 Compare leaves IP7 set.
  always_comb begin
    cause_d = cause_q;
    if (do_exc)
      cause_d[6:2] = bus.exc_code;
    else if (do_mtc0 && bus.wr_cs == CS_CAUSE)
      cause_d[9:8] = bus.wr_data[9:8];
    else if (do_mtc0 && bus.wr_cs == CS_COMPARE)
      cause_d[15] = 1'b0;
    if (timer_hit)
      cause_d[15] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 32'h0;
      compare_q <= 32'hFFFF_FFFF;
      status_q  <= 32'h0000_0002;
      cause_q   <= 32'h0;
      epc_q     <= 32'h0;
    end else begin
      count_q <= (do_mtc0 && bus.wr_cs == CS_COUNT) ? bus.wr_data : count_q + 32'd1;
      cause_q <= cause_d;
      if (do_mtc0 && bus.wr_cs == CS_COMPARE)
        compare_q <= bus.wr_data;
      if (do_exc)
        status_q[1] <= 1'b1;
      else if (do_eret)
        status_q[1] <= 1'b0;
      else if (do_mtc0 && bus.wr_cs == CS_STATUS)
        status_q <= (status_q & ~STATUS_WMASK) | (bus.wr_data & STATUS_WMASK);
      // A nested exception (EXL already set) keeps the original return address.
      if (do_exc) begin
        if (!status_q[1])
          epc_q <= bus.exc_pc;
      end else if (do_mtc0 && bus.wr_cs == CS_EPC) begin
        epc_q <= bus.wr_data;
      end
    end
  end

  always_comb begin
    bus.id_rdata = 32'h0;
    if (bus.id_sel == 3'd0) begin
      case (bus.id_cs)
        CS_COUNT:   bus.id_rdata = count_q;
        CS_COMPARE: bus.id_rdata = compare_q;
        CS_STATUS:  bus.id_rdata = status_q;
        CS_CAUSE:   bus.id_rdata = cause_q;
        CS_EPC:     bus.id_rdata = epc_q;
        default:    bus.id_rdata = 32'h0;
      endcase
    end
  end

  assign bus.epc_out     = epc_q;
  assign bus.status_exl  = status_q[1];
  assign bus.irq_pending = (|(cause_q[15:8] & status_q[15:8])) & status_q[0] & ~status_q[1];
endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios then random traffic, checked against an array-based CP0 model.
module tb_cp0_regfile;
  logic clk;
  logic rst;
  cp0_regfile_if bus_if ();

  cp0_regfile dut (.clk(clk), .rst(rst), .bus(bus_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] m [0:31];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] cs, input logic [2:0] sel);
    if (sel != 3'd0) return 32'h0;
    if (cs == 5'd9 || cs == 5'd11 || cs == 5'd12 || cs == 5'd13 || cs == 5'd14) return m[cs];
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    m[11] = 32'hFFFF_FFFF;
    m[12] = 32'h0000_0002;
  endtask

  // Applies the architectural rules of one clock edge to the register array.
  task automatic model_edge();
    logic [31:0] nx [0:31];
    logic hit;
    nx = m;
    hit = (m[9] == m[11]);
    nx[9] = m[9] + 32'd1;
    if (bus_if.exc_req) begin
      if (!m[12][1]) nx[14] = bus_if.exc_pc;
      nx[13][6:2] = bus_if.exc_code;
      nx[12][1] = 1'b1;
    end else if (bus_if.wr_cp0op == 3'b100) begin
      nx[12][1] = 1'b0;
    end else if (bus_if.wr_cp0op == 3'b010 && bus_if.wr_sel == 3'd0) begin
      case (bus_if.wr_cs)
        5'd9:  nx[9] = bus_if.wr_data;
        5'd11: begin nx[11] = bus_if.wr_data; nx[13][15] = 1'b0; end
        5'd12: begin
          nx[12][15:8] = bus_if.wr_data[15:8];
          nx[12][1:0]  = bus_if.wr_data[1:0];
        end
        5'd13: nx[13][9:8] = bus_if.wr_data[9:8];
        5'd14: nx[14] = bus_if.wr_data;
        default: ;
      endcase
    end
    if (hit) nx[13][15] = 1'b1;
    m = nx;
  endtask

  task automatic check_all(input string tag);
    logic irq;
    irq = (|(m[13][15:8] & m[12][15:8])) && m[12][0] && !m[12][1];
    check({tag, ".id_rdata"}, bus_if.id_rdata, model_rd(bus_if.id_cs, bus_if.id_sel));
    check({tag, ".epc_out"}, bus_if.epc_out, m[14]);
    check({tag, ".irq_pending"}, {31'b0, bus_if.irq_pending}, {31'b0, irq});
    check({tag, ".status_exl"}, {31'b0, bus_if.status_exl}, {31'b0, m[12][1]});
  endtask

  task automatic step(input string tag, input logic [2:0] op, input logic [4:0] cs,
                      input logic [2:0] sel, input logic [31:0] data, input logic exc,
                      input logic [31:0] pc, input logic [4:0] code, input logic [4:0] rcs);
    bus_if.wr_cp0op = op;
    bus_if.wr_cs    = cs;
    bus_if.wr_sel   = sel;
    bus_if.wr_data  = data;
    bus_if.exc_req  = exc;
    bus_if.exc_pc   = pc;
    bus_if.exc_code = code;
    bus_if.id_cs    = rcs;
    bus_if.id_sel   = 3'd0;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic [4:0] rcs);
    step(tag, 3'b000, 5'd0, 3'd0, 32'h0, 1'b0, 32'h0, 5'd0, rcs);
  endtask

  task automatic mtc0(input string tag, input logic [4:0] cs, input logic [31:0] data, input logic [4:0] rcs);
    step(tag, 3'b010, cs, 3'd0, data, 1'b0, 32'h0, 5'd0, rcs);
  endtask

  initial begin
    int irq_seen;
    rst = 1'b1;
    bus_if.wr_cp0op = 3'b000; bus_if.wr_cs = 5'd0; bus_if.wr_sel = 3'd0; bus_if.wr_data = 32'h0;
    bus_if.exc_req = 1'b0; bus_if.exc_pc = 32'h0; bus_if.exc_code = 5'd0;
    bus_if.id_cs = 5'd11; bus_if.id_sel = 3'd0;
    model_reset();
    #2;
    check("reset.compare", bus_if.id_rdata, 32'hFFFF_FFFF);
    check("reset.epc_out", bus_if.epc_out, 32'h0);
    check("reset.status_exl", {31'b0, bus_if.status_exl}, 32'd1);
    check("reset.irq_pending", {31'b0, bus_if.irq_pending}, 32'd0);
    bus_if.id_cs = 5'd12;
    #1 check("reset.status", bus_if.id_rdata, 32'h0000_0002);
    @(negedge clk);
    rst = 1'b0;

    idle("first_tick", 5'd9);
    check("first_tick.count", bus_if.id_rdata, 32'd1);

    mtc0("mtc0_epc", 5'd14, 32'hBFC0_0100, 5'd14);
    check("mtc0_epc.rdata", bus_if.id_rdata, 32'hBFC0_0100);
    check("mtc0_epc.epc_out", bus_if.epc_out, 32'hBFC0_0100);

    mtc0("mtc0_status", 5'd12, 32'hFFFF_8001, 5'd12);
    check("mtc0_status.masked", bus_if.id_rdata, 32'h0000_8001);

    step("exc1", 3'b000, 5'd0, 3'd0, 32'h0, 1'b1, 32'h8000_0040, 5'd8, 5'd13);
    check("exc1.epc", bus_if.epc_out, 32'h8000_0040);
    check("exc1.code", {27'b0, bus_if.id_rdata[6:2]}, 32'd8);
    check("exc1.exl", {31'b0, bus_if.status_exl}, 32'd1);

    step("exc2", 3'b000, 5'd0, 3'd0, 32'h0, 1'b1, 32'h0000_1234, 5'd4, 5'd13);
    check("exc2.epc_kept", bus_if.epc_out, 32'h8000_0040);
    check("exc2.code", {27'b0, bus_if.id_rdata[6:2]}, 32'd4);

    step("eret", 3'b100, 5'd0, 3'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd14);
    check("eret.exl", {31'b0, bus_if.status_exl}, 32'd0);
    check("eret.epc_kept", bus_if.epc_out, 32'h8000_0040);

    step("exc_vs_mtc0", 3'b010, 5'd14, 3'd0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0180, 5'd10, 5'd14);
    check("exc_vs_mtc0.epc", bus_if.epc_out, 32'h8000_0180);
    step("eret2", 3'b100, 5'd0, 3'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd12);

    mtc0("cause_sw", 5'd13, 32'hFFFF_FFFF, 5'd13);
    check("cause_sw.bits", bus_if.id_rdata & 32'h0000_FF00, 32'h0000_0300);
    mtc0("cause_sw_clr", 5'd13, 32'h0, 5'd13);
    mtc0("sel_ignored", 5'd14, 32'h1111_1111, 5'd14);
    step("sel_nz", 3'b010, 5'd14, 3'd1, 32'h2222_2222, 1'b0, 32'h0, 5'd0, 5'd14);
    check("sel_nz.epc", bus_if.epc_out, 32'h1111_1111);

    mtc0("count_set", 5'd9, 32'd5, 5'd9);
    check("count_set.count", bus_if.id_rdata, 32'd5);
    mtc0("compare_set", 5'd11, 32'd20, 5'd9);
    irq_seen = 0;
    for (int i = 0; i < 40 && irq_seen == 0; i++) begin
      idle("timer_wait", 5'd9);
      if (bus_if.irq_pending) begin
        irq_seen = 1;
        check("timer.count_at_irq", bus_if.id_rdata, 32'd21);
      end
    end
    check("timer.irq_seen", irq_seen, 32'd1);
    mtc0("compare_clr", 5'd11, 32'h0001_0000, 5'd13);
    check("compare_clr.irq", {31'b0, bus_if.irq_pending}, 32'd0);
    check("compare_clr.ip7", {31'b0, bus_if.id_rdata[15]}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      logic [4:0] cs;
      case ($urandom_range(0, 3))
        0: op = 3'b000;
        1, 2: op = 3'b010;
        default: op = 3'b100;
      endcase
      case ($urandom_range(0, 5))
        0: cs = 5'd9;
        1: cs = 5'd11;
        2: cs = 5'd12;
        3: cs = 5'd13;
        4: cs = 5'd14;
        default: cs = 5'($urandom_range(0, 31));
      endcase
      step("random", op, cs, ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
           ($urandom_range(0, 7) == 0), $urandom, 5'($urandom_range(0, 31)),
           5'($urandom_range(8, 15)));
    end

    mtc0("pre_rst", 5'd14, 32'hCAFE_0000, 5'd9);
    bus_if.wr_cp0op = 3'b010; bus_if.wr_cs = 5'd14; bus_if.wr_data = 32'h5555_5555;
    bus_if.exc_req = 1'b1; bus_if.id_cs = 5'd9;
    #3 rst = 1'b1;
    #1;
    check("mid_rst.count", bus_if.id_rdata, 32'd0);
    check("mid_rst.epc_out", bus_if.epc_out, 32'h0);
    check("mid_rst.status_exl", {31'b0, bus_if.status_exl}, 32'd1);
    check("mid_rst.irq_pending", {31'b0, bus_if.irq_pending}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle("post_rst", 5'd9);
    check("post_rst.count", bus_if.id_rdata, 32'd1);
    idle("post_rst2", 5'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
